spi_slave_sync: RTL and testbench

SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_sync.sv | 36 +++
 rtl/spi_slave_sync.sv | 255 +++++++++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the synchronous SPI slave: default word length,
// default synchronizer depth, SPI mode encodings and the frame FSM states.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_WIDTH_DEFAULT       = 8;
    localparam int SPI_SYNC_STAGES_DEFAULT = 2;

    // i_mode = {CPOL, CPHA}
    localparam int MODE_CPOL_BIT = 1;
    localparam int MODE_CPHA_BIT = 0;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,   // CPOL=0 CPHA=0
        SPI_MODE1 = 2'b01,   // CPOL=0 CPHA=1
        SPI_MODE2 = 2'b10,   // CPOL=1 CPHA=0
        SPI_MODE3 = 2'b11    // CPOL=1 CPHA=1
    } spi_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Multi-flop synchronizer for one asynchronous input bit.
//   i_clk   system clock
//   i_rst   synchronous active-high reset, loads RST_VAL into every stage
//   i_d     asynchronous input
//   o_q     synchronized output (last stage)
// -----------------------------------------------------------------------------
module spi_sync
    import spi_pkg::*;
#(
    parameter int   STAGES  = SPI_SYNC_STAGES_DEFAULT,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// -----------------------------------------------------------------------------
// spi_slave_sync
// SPI slave fully clocked by the system clock. sclk, cs_n and mosi are
// oversampled through synchronizers; edges are found by comparing against a
// history flop. Supports all four SPI modes, MSB first, single-word transmit
// buffer with underrun flag.
//   i_clk, i_rst            system clock, synchronous active-high reset
//   i_mode                  {CPOL,CPHA}, latched at frame start
//   i_sclk, i_cs_n, i_mosi  asynchronous SPI bus inputs
//   o_miso, o_miso_oe       serial data out and its enable
//   i_tx_data/valid, o_tx_ready   transmit buffer write handshake
//   o_rx_data, o_rx_valid   received word and its one-cycle strobe
//   o_busy                  frame active
//   o_underrun              word started with empty transmit buffer
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | not selected; miso disabled, waiting for cs_n falling edge
// ST_ACTIVE | selected; sampling/shifting on sclk edges, miso enabled
// -----------------------------------------------------------------------------
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_mode,
    input  logic             i_sclk,
    input  logic             i_cs_n,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_busy,
    output logic             o_underrun
);

    localparam int CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    // ---------------------------------------------------------------- inputs
    logic cs_s, sclk_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs_n), .o_q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sclk), .o_q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi), .o_q(mosi_s)
    );

    logic                cs_prev_q, sclk_prev_q;
    logic [SETTLE_W-1:0] settle_q;
    logic                armed_q;

    // The cs_n synchronizer resets to 1, so a cs_n held low through reset
    // would look like a falling edge once the chain refills. Falling edges
    // are only honoured after cs_n has been seen high with a chain that
    // holds real samples again.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            settle_q    <= SETTLE_W'(SYNC_STAGES);
            armed_q     <= 1'b0;
        end else begin
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            if (settle_q != '0) begin
                settle_q <= settle_q - 1'b1;
            end else if (cs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    // ------------------------------------------------------------------- FSM
    spi_state_e state_q, state_d;
    logic       frame_start, frame_end;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- datapath
    spi_mode_e         mode_q, mode_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-2:0]  rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]  rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic              miso_q, miso_d;
    logic              skip_q, skip_d;
    logic              start_pend_q, start_pend_d;
    logic [WIDTH-1:0]  buf_q, buf_d;
    logic              buf_full_q, buf_full_d;

    logic              active_run, lead_edge, trail_edge;
    logic              sample_edge, shift_edge, last_sample, word_start;
    logic [WIDTH-1:0]  rx_next, load_word;

    assign mode_d = frame_start ? spi_mode_e'(i_mode) : mode_q;

    // Edges in the cs_n rising cycle belong to no word.
    assign active_run  = (state_q == ST_ACTIVE) && !cs_rise;
    assign lead_edge   = mode_q[MODE_CPOL_BIT] ? sclk_fall : sclk_rise;
    assign trail_edge  = mode_q[MODE_CPOL_BIT] ? sclk_rise : sclk_fall;
    assign sample_edge = active_run & (mode_q[MODE_CPHA_BIT] ? trail_edge : lead_edge);
    assign shift_edge  = active_run & (mode_q[MODE_CPHA_BIT] ? lead_edge : trail_edge);
    assign last_sample = sample_edge && (bit_cnt_q == CNT_W'(WIDTH - 1));
    assign word_start  = frame_start | (start_pend_q & active_run);
    assign rx_next     = {rx_shift_q, mosi_s};

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        underrun_d   = 1'b0;
        tx_shift_d   = tx_shift_q;
        miso_d       = miso_q;
        skip_d       = skip_q;
        start_pend_d = 1'b0;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        load_word    = '0;

        // Frame entry and abort both drop any partial word.
        if (frame_start || frame_end) begin
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            skip_d     = 1'b0;
        end

        if (sample_edge) begin
            rx_shift_d = rx_next[WIDTH-2:0];
            if (last_sample) begin
                bit_cnt_d    = '0;
                rx_data_d    = rx_next;
                rx_valid_d   = 1'b1;
                start_pend_d = 1'b1;
                // CPHA=0 already presents the next MSB at load time, so the
                // shift edge closing this word must not advance it.
                skip_d       = ~mode_q[MODE_CPHA_BIT];
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        // "Presenting" moves the next unsent bit from tx_shift onto miso.
        if (shift_edge) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                miso_d     = tx_shift_q[WIDTH-1];
                tx_shift_d = tx_shift_q << 1;
            end
        end

        if (word_start) begin
            load_word  = buf_full_q ? buf_q : '0;
            underrun_d = ~buf_full_q;
            buf_full_d = 1'b0;
            if (mode_d[MODE_CPHA_BIT]) begin
                tx_shift_d = load_word;
                if (frame_start) miso_d = 1'b0;
            end else begin
                miso_d     = load_word[WIDTH-1];
                tx_shift_d = load_word << 1;
            end
        end

        // Evaluated after the load so a same-cycle write refills the buffer.
        if (i_tx_valid && !buf_full_q) begin
            buf_d      = i_tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q       <= SPI_MODE0;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            tx_shift_q   <= '0;
            miso_q       <= 1'b0;
            skip_q       <= 1'b0;
            start_pend_q <= 1'b0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            underrun_q   <= underrun_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            skip_q       <= skip_d;
            start_pend_q <= start_pend_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
        end
    end

    assign o_busy     = (state_q == ST_ACTIVE);
    assign o_miso_oe  = (state_q == ST_ACTIVE);
    assign o_miso     = o_miso_oe & miso_q;
    assign o_tx_ready = ~buf_full_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
module tb_spi_slave_sync;

    localparam int W = 8;
    localparam int H = 5;   // sclk half period in i_clk cycles

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [1:0]   i_mode = 2'b00;
    logic         i_sclk = 1'b0;
    logic         i_cs_n = 1'b1;
    logic         i_mosi = 1'b0;
    logic         o_miso, o_miso_oe;
    logic [W-1:0] i_tx_data = '0;
    logic         i_tx_valid = 1'b0;
    logic         o_tx_ready;
    logic [W-1:0] o_rx_data;
    logic         o_rx_valid, o_busy, o_underrun;

    spi_slave_sync #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode),
        .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
        .o_miso(o_miso), .o_miso_oe(o_miso_oe),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
        .o_busy(o_busy), .o_underrun(o_underrun)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // running event monitor; the test reads deltas
    int           rxv_total = 0;
    int           und_total = 0;
    logic [W-1:0] rx_last = '0, rx_prev = '0;

    always @(negedge i_clk) begin
        if (o_rx_valid) begin
            rxv_total = rxv_total + 1;
            rx_prev   = rx_last;
            rx_last   = o_rx_data;
        end
        if (o_underrun) und_total = und_total + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_buf(input logic [W-1:0] d);
        int n;
        @(negedge i_clk);
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        n = 0;
        while (!o_tx_ready && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        check("tx_write_accepted", 32'(n < 400), 32'd1);
        @(negedge i_clk);
        i_tx_valid = 1'b0;
    endtask

    // SPI master: drives nbits MSB first from mosi_bits[nbits-1:0],
    // captures miso at each master sample edge.
    task automatic spi_frame(input logic [1:0] mode, input int nbits,
                             input logic [15:0] mosi_bits, input bit raise_cs,
                             output logic [15:0] miso_bits);
        logic cpol, cpha;
        cpol      = mode[1];
        cpha      = mode[0];
        miso_bits = '0;
        @(negedge i_clk);
        i_mode = mode;
        i_sclk = cpol;
        repeat (H) @(negedge i_clk);
        i_cs_n = 1'b0;
        repeat (H) @(negedge i_clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                i_mosi = mosi_bits[i];
                repeat (H) @(negedge i_clk);
                i_sclk = ~cpol;
                miso_bits[i] = o_miso;
                repeat (H) @(negedge i_clk);
                i_sclk = cpol;
            end else begin
                i_sclk = ~cpol;
                i_mosi = mosi_bits[i];
                repeat (H) @(negedge i_clk);
                i_sclk = cpol;
                miso_bits[i] = o_miso;
                repeat (H) @(negedge i_clk);
            end
        end
        if (raise_cs) begin
            repeat (H) @(negedge i_clk);
            i_cs_n = 1'b1;
            i_mosi = 1'b0;
            repeat (3 * H) @(negedge i_clk);
        end
    endtask

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] mosi;
        logic         pre;
        logic [W-1:0] pre_data;
        logic         refill;
        logic [W-1:0] refill_data;
        logic [W-1:0] exp_miso;
        logic [W-1:0] exp_rx;
        int           exp_valid;
        int           exp_und;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] mb;
        int          v0, u0;

        vecs[0] = '{2'd0, 8'h3C, 1'b1, 8'hA5, 1'b0, 8'h00, 8'hA5, 8'h3C, 1, 1};
        vecs[1] = '{2'd1, 8'h7E, 1'b1, 8'h81, 1'b1, 8'h00, 8'h81, 8'h7E, 1, 0};
        vecs[2] = '{2'd2, 8'h7E, 1'b1, 8'h81, 1'b1, 8'h00, 8'h81, 8'h7E, 1, 0};
        vecs[3] = '{2'd3, 8'h7E, 1'b1, 8'h81, 1'b1, 8'h00, 8'h81, 8'h7E, 1, 0};
        vecs[4] = '{2'd0, 8'h96, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h96, 1, 2};

        // reset state
        repeat (4) @(negedge i_clk);
        check("rst_tx_ready", 32'(o_tx_ready), 32'd1);
        check("rst_busy",     32'(o_busy),     32'd0);
        check("rst_miso_oe",  32'(o_miso_oe),  32'd0);
        check("rst_miso",     32'(o_miso),     32'd0);
        check("rst_rx_data",  32'(o_rx_data),  32'd0);
        check("rst_rx_valid", 32'(o_rx_valid), 32'd0);
        check("rst_underrun", 32'(o_underrun), 32'd0);
        i_rst = 1'b0;
        repeat (10) @(negedge i_clk);

        // single-word frames across all modes
        for (int k = 0; k < 5; k++) begin
            if (vecs[k].pre) write_buf(vecs[k].pre_data);
            v0 = rxv_total;
            u0 = und_total;
            fork
                spi_frame(vecs[k].mode, W, {8'h00, vecs[k].mosi}, 1'b1, mb);
                begin
                    if (vecs[k].refill) write_buf(vecs[k].refill_data);
                end
            join
            check($sformatf("v%0d_miso", k),     32'(mb[7:0]),       32'(vecs[k].exp_miso));
            check($sformatf("v%0d_rx_data", k),  32'(o_rx_data),     32'(vecs[k].exp_rx));
            check($sformatf("v%0d_rx_valid", k), 32'(rxv_total - v0), 32'(vecs[k].exp_valid));
            check($sformatf("v%0d_underrun", k), 32'(und_total - u0), 32'(vecs[k].exp_und));
            check($sformatf("v%0d_busy_end", k), 32'(o_busy),        32'd0);
            check($sformatf("v%0d_oe_end", k),   32'(o_miso_oe),     32'd0);
        end

        // back-to-back words in one frame, buffer refilled during word 1
        write_buf(8'h11);
        v0 = rxv_total;
        u0 = und_total;
        fork
            spi_frame(2'd0, 2 * W, 16'hA1B2, 1'b1, mb);
            write_buf(8'h22);
        join
        check("b2b_miso",     32'(mb),              32'h1122);
        check("b2b_rx_valid", 32'(rxv_total - v0),  32'd2);
        check("b2b_rx_first", 32'(rx_prev),         32'hA1);
        check("b2b_rx_last",  32'(rx_last),         32'hB2);
        check("b2b_underrun", 32'(und_total - u0),  32'd1);

        // abort after 5 bits; refilled buffer must survive
        write_buf(8'h5A);
        v0 = rxv_total;
        fork
            spi_frame(2'd0, 5, 16'h001F, 1'b1, mb);
            write_buf(8'h99);
        join
        check("abort_rx_valid", 32'(rxv_total - v0), 32'd0);
        check("abort_busy",     32'(o_busy),         32'd0);
        check("abort_rx_held",  32'(o_rx_data),      32'hB2);
        check("abort_buf_kept", 32'(o_tx_ready),     32'd0);
        v0 = rxv_total;
        spi_frame(2'd0, W, 16'h004D, 1'b1, mb);
        check("post_abort_miso", 32'(mb[7:0]),        32'h99);
        check("post_abort_rx",   32'(o_rx_data),      32'h4D);
        check("post_abort_vld",  32'(rxv_total - v0), 32'd1);

        // reset three bits into a word, cs_n still low through and after reset
        spi_frame(2'd0, 3, 16'h0005, 1'b0, mb);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("midrst_busy",     32'(o_busy),     32'd0);
        check("midrst_miso_oe",  32'(o_miso_oe),  32'd0);
        check("midrst_miso",     32'(o_miso),     32'd0);
        check("midrst_tx_ready", 32'(o_tx_ready), 32'd1);
        check("midrst_rx_data",  32'(o_rx_data),  32'd0);
        check("midrst_rx_valid", 32'(o_rx_valid), 32'd0);
        check("midrst_underrun", 32'(o_underrun), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (20) @(negedge i_clk);
        check("midrst_stay_idle", 32'(o_busy), 32'd0);
        i_cs_n = 1'b1;
        i_sclk = 1'b0;
        repeat (10) @(negedge i_clk);
        write_buf(8'h3E);
        v0 = rxv_total;
        spi_frame(2'd0, W, 16'h00C3, 1'b1, mb);
        check("postrst_rx",   32'(o_rx_data),      32'hC3);
        check("postrst_miso", 32'(mb[7:0]),        32'h3E);
        check("postrst_vld",  32'(rxv_total - v0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
